blur_frame_sequencer: RTL



---
 rtl/blur_frame_sequencer.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/blur_frame_sequencer.sv
// rtl/blur_frame_sequencer.sv - raster frame sequencer feeding the edge-detection filter chain
// Reads one frame from BRAM, emits vsync/hsync/de video with blanking, flush lines and a drain delay.
module blur_frame_sequencer #(
  parameter int WIDTH       = 8,
  parameter int H_RES       = 80,
  parameter int V_RES       = 60,
  parameter int H_BLANK     = 4,
  parameter int VS_LEN      = 2,
  parameter int FLUSH_LINES = 1,
  parameter int DRAIN_CYC   = 8,
  parameter int ADDR_W      = $clog2(H_RES*V_RES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic              i_pause,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [WIDTH-1:0]  i_rd_data,
  output logic              o_vsync,
  output logic              o_hsync,
  output logic              o_de,
  output logic [WIDTH-1:0]  o_data
);

  localparam int TMR_MAX = (H_BLANK > VS_LEN) ?
                           ((H_BLANK > DRAIN_CYC) ? H_BLANK : DRAIN_CYC) :
                           ((VS_LEN > DRAIN_CYC) ? VS_LEN : DRAIN_CYC);
  localparam int TMR_W = $clog2(TMR_MAX + 1);
  localparam int COL_W = $clog2(H_RES + 1);
  localparam int ROW_W = $clog2(V_RES + FLUSH_LINES + 1);

  localparam logic [TMR_W-1:0] VS_LAST  = TMR_W'(VS_LEN - 1);
  localparam logic [TMR_W-1:0] HB_LAST  = TMR_W'(H_BLANK - 1);
  localparam logic [TMR_W-1:0] DR_LAST  = TMR_W'(DRAIN_CYC - 1);
  localparam logic [TMR_W-1:0] DR_SAT   = TMR_W'(DRAIN_CYC);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(H_RES - 1);
  localparam logic [ROW_W-1:0] ROWS     = ROW_W'(V_RES);
  localparam logic [ROW_W-1:0] FLUSHES  = ROW_W'(FLUSH_LINES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_VSYNC,
    S_LINE,
    S_HBLANK,
    S_FLUSH,
    S_DRAIN
  } state_t;

  state_t            state;
  logic [TMR_W-1:0]  tmr;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  rows_done;
  logic [ROW_W-1:0]  flush_done;
  logic [ADDR_W-1:0] rd_ptr;
  logic              pix_act;
  logic              pix_flush;
  logic              de_d1;
  logic              flush_d1;
  logic [TMR_W-1:0]  since_de;
  logic [TMR_W-1:0]  idle_cyc;

  // Cycles elapsed since the most recent o_de, valid even in the cycle o_de is high.
  assign idle_cyc = o_de ? '0 : since_de;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      tmr        <= '0;
      col        <= '0;
      rows_done  <= '0;
      flush_done <= '0;
      rd_ptr     <= '0;
      pix_act    <= 1'b0;
      pix_flush  <= 1'b0;
      de_d1      <= 1'b0;
      flush_d1   <= 1'b0;
      since_de   <= '0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_rd_en    <= 1'b0;
      o_rd_addr  <= '0;
      o_vsync    <= 1'b0;
      o_hsync    <= 1'b0;
      o_de       <= 1'b0;
      o_data     <= '0;
    end else begin
      o_done   <= 1'b0;
      // Two-stage pixel pipeline: BRAM read latency, then the output register.
      de_d1    <= pix_act;
      flush_d1 <= pix_flush;
      o_de     <= de_d1;
      o_data   <= (de_d1 && !flush_d1) ? i_rd_data : '0;
      o_hsync  <= o_de && !de_d1;
      if (o_de)
        since_de <= TMR_W'(1);
      else if (since_de != DR_SAT)
        since_de <= since_de + TMR_W'(1);

      case (state)
        S_IDLE: begin
          if (i_start && !o_done) begin
            state      <= S_VSYNC;
            tmr        <= '0;
            rows_done  <= '0;
            flush_done <= '0;
            rd_ptr     <= '0;
            o_busy     <= 1'b1;
            o_vsync    <= 1'b1;
          end
        end
        S_VSYNC: begin
          if (tmr != VS_LAST) begin
            tmr <= tmr + TMR_W'(1);
          end else if (!i_pause) begin
            state     <= S_LINE;
            o_vsync   <= 1'b0;
            o_rd_en   <= 1'b1;
            pix_act   <= 1'b1;
            o_rd_addr <= rd_ptr;
            rd_ptr    <= rd_ptr + ADDR_W'(1);
            col       <= '0;
          end
        end
        S_LINE: begin
          if (col == COL_LAST) begin
            state     <= S_HBLANK;
            tmr       <= '0;
            o_rd_en   <= 1'b0;
            pix_act   <= 1'b0;
            rows_done <= rows_done + ROW_W'(1);
          end else begin
            col       <= col + COL_W'(1);
            o_rd_addr <= rd_ptr;
            rd_ptr    <= rd_ptr + ADDR_W'(1);
          end
        end
        S_HBLANK: begin
          if (tmr != HB_LAST) begin
            tmr <= tmr + TMR_W'(1);
          end else if (!i_pause) begin
            if (rows_done < ROWS) begin
              state     <= S_LINE;
              o_rd_en   <= 1'b1;
              pix_act   <= 1'b1;
              o_rd_addr <= rd_ptr;
              rd_ptr    <= rd_ptr + ADDR_W'(1);
              col       <= '0;
            end else if (flush_done < FLUSHES) begin
              state     <= S_FLUSH;
              pix_act   <= 1'b1;
              pix_flush <= 1'b1;
              col       <= '0;
            end else begin
              state <= S_DRAIN;
            end
          end
        end
        S_FLUSH: begin
          if (col == COL_LAST) begin
            state      <= S_HBLANK;
            tmr        <= '0;
            pix_act    <= 1'b0;
            pix_flush  <= 1'b0;
            flush_done <= flush_done + ROW_W'(1);
          end else begin
            col <= col + COL_W'(1);
          end
        end
        S_DRAIN: begin
          if (idle_cyc >= DR_LAST) begin
            state  <= S_IDLE;
            o_done <= 1'b1;
            o_busy <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
